// File: rtl/spi_slave_responder.sv
// spi_slave_responder
//
// SPI target-side responder for the 32-bit command link. Receives 32-bit
// command words LSB-first. When CMD_WORD[3:0] == READ_OPCODE, a 32-bit data
// word fetched from the register file is returned LSB-first in the next
// chip-select frame. SPI_SCLK is only oversampled, never used as a clock.
//
// Ports
//   CLOCK      in   system clock, at least 8x the SPI_SCLK frequency
//   RESET      in   synchronous, active-high reset
//   SPI_SCLK   in   SPI clock, idle low; MOSI valid on its rising edge
//   SPI_CS     in   chip select, active low
//   SPI_MOSI   in   serial data from the master
//   SPI_MISO   out  serial data to the master (driven 0 outside read frames)
//   CMD_WORD   out  last complete command word, bit 0 received first
//   CMD_VALID  out  one-cycle pulse when CMD_WORD updates
//   RD_REQ     out  one-cycle pulse with CMD_VALID for read commands
//   RD_ACK     in   register file presents RD_DATA
//   RD_DATA    in   read-back word
//   RD_MISS    out  one-cycle pulse: read frame started without RD_ACK
//   FRAME_ERR  out  one-cycle pulse: malformed frame
//   BUSY       out  high whenever the FSM is not idle
//   DBG_STATE  out  current FSM state encoding
//
// Read handshake: RD_REQ pulses for one cycle when a read command completes.
// The register file answers by raising RD_ACK for at least one cycle with
// RD_DATA valid in that cycle; RD_ACK may coincide with the RD_REQ cycle.
// Only the first RD_ACK between RD_REQ and the read-frame CS fall is taken;
// RD_ACK outside that window is ignored. There is no back-pressure.

module spi_slave_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [3:0] READ_OPCODE = 4'b1110
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        SPI_SCLK,
  input  logic        SPI_CS,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  output logic [31:0] CMD_WORD,
  output logic        CMD_VALID,
  output logic        RD_REQ,
  input  logic        RD_ACK,
  input  logic [31:0] RD_DATA,
  output logic        RD_MISS,
  output logic        FRAME_ERR,
  output logic        BUSY,
  output logic [1:0]  DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_CMD_SHIFT = 2'd1,
    S_RD_WAIT   = 2'd2,
    S_RD_SHIFT  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Synchronizers run freely (no reset) so that after RESET the edge
  // detectors reflect the true pin levels rather than a forced value that
  // could fake a CS edge.
  logic [2:0] sync_q [SYNC_STAGES];
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_prev, cs_prev;

  always_ff @(posedge CLOCK) begin
    sync_q[0] <= {SPI_SCLK, SPI_CS, SPI_MOSI};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_q[i] <= sync_q[i-1];
    end
    sclk_prev <= sclk_s;
    cs_prev   <= cs_s;
  end

  assign sclk_s = sync_q[SYNC_STAGES-1][2];
  assign cs_s   = sync_q[SYNC_STAGES-1][1];
  assign mosi_s = sync_q[SYNC_STAGES-1][0];

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise = !sclk_prev &&  sclk_s;
  assign sclk_fall =  sclk_prev && !sclk_s;
  assign cs_fall   =  cs_prev   && !cs_s;
  assign cs_rise   = !cs_prev   &&  cs_s;

  logic [31:0] cmd_sr_q;
  logic [31:0] tx_q;
  logic [5:0]  count_q;
  logic        overrun_q;
  logic        ack_seen_q;
  // Set by reset; blocks a new frame until CS has been seen high, so a frame
  // already in progress when reset deasserts is ignored silently.
  logic        cs_hold_q;

  logic cmd_accept, rd_start, frame_err_d, rd_miss_d;

  // Next-state and event decode
  always_comb begin
    state_d     = state_q;
    cmd_accept  = 1'b0;
    rd_start    = 1'b0;
    frame_err_d = 1'b0;
    rd_miss_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cs_fall && !cs_hold_q) state_d = S_CMD_SHIFT;
      end
      S_CMD_SHIFT: begin
        if (cs_rise) begin
          state_d = S_IDLE;
          if (count_q == 6'd32 && !overrun_q) begin
            cmd_accept = 1'b1;
            if (cmd_sr_q[3:0] == READ_OPCODE) begin
              rd_start = 1'b1;
              state_d  = S_RD_WAIT;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      S_RD_WAIT: begin
        if (cs_fall) begin
          state_d   = S_RD_SHIFT;
          rd_miss_d = !ack_seen_q;
        end
      end
      S_RD_SHIFT: begin
        if (cs_rise) begin
          state_d     = S_IDLE;
          frame_err_d = (count_q != 6'd32);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath: shift registers, counter, registered pulses and MISO
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cmd_sr_q   <= '0;
      tx_q       <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      ack_seen_q <= 1'b0;
      cs_hold_q  <= 1'b1;
      CMD_WORD   <= '0;
      CMD_VALID  <= 1'b0;
      RD_REQ     <= 1'b0;
      RD_MISS    <= 1'b0;
      FRAME_ERR  <= 1'b0;
      SPI_MISO   <= 1'b0;
    end else begin
      CMD_VALID <= cmd_accept;
      RD_REQ    <= rd_start;
      FRAME_ERR <= frame_err_d;
      RD_MISS   <= rd_miss_d;
      if (cs_s) cs_hold_q <= 1'b0;
      if (cmd_accept) CMD_WORD <= cmd_sr_q;

      case (state_q)
        S_IDLE: begin
          count_q    <= '0;
          overrun_q  <= 1'b0;
          ack_seen_q <= 1'b0;
          SPI_MISO   <= 1'b0;
        end
        S_CMD_SHIFT: begin
          // A CS rise in the same cycle discards the SCLK edge.
          if (!cs_rise && sclk_rise) begin
            if (count_q < 6'd32) begin
              cmd_sr_q[count_q[4:0]] <= mosi_s;
              count_q                <= count_q + 6'd1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
        end
        S_RD_WAIT: begin
          count_q <= '0;
          if (cs_fall) begin
            if (!ack_seen_q) tx_q <= '0;
            SPI_MISO <= ack_seen_q ? tx_q[0] : 1'b0;
          end else if (RD_ACK && !ack_seen_q) begin
            tx_q       <= RD_DATA;
            ack_seen_q <= 1'b1;
          end
        end
        S_RD_SHIFT: begin
          if (cs_rise) begin
            SPI_MISO <= 1'b0;
          end else begin
            // Saturate so a runaway frame can never wrap back to 32.
            if (sclk_rise && count_q != 6'h3F) count_q <= count_q + 6'd1;
            if (sclk_fall) begin
              tx_q     <= {1'b0, tx_q[31:1]};
              SPI_MISO <= tx_q[1];
            end
          end
        end
        default: begin
          SPI_MISO <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY      = (state_q != S_IDLE);
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Testbench for spi_slave_responder: a behavioural SPI master, a register
// file responder, a pulse monitor and a model of the expected frame outcome.

module tb_spi_slave_responder;

  localparam int         HALF  = 8;   // CLOCK cycles per SCLK half period
  localparam int         GAP   = 16;  // CS-high cycles between frames
  localparam logic [3:0] RD_OP = 4'b1110;

  logic        clk = 1'b0;
  logic        RESET, SPI_SCLK, SPI_CS, SPI_MOSI, SPI_MISO;
  logic [31:0] CMD_WORD, RD_DATA;
  logic        CMD_VALID, RD_REQ, RD_ACK, RD_MISS, FRAME_ERR, BUSY;
  logic [1:0]  DBG_STATE;

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor counters (written only by the monitor)
  int n_valid = 0, n_req = 0, n_miss = 0, n_ferr = 0;
  int n_miso_hi = 0, n_busy = 0, n_consec = 0;
  logic p_valid = 0, p_req = 0, p_miss = 0, p_ferr = 0;
  logic [31:0] got_q[$];

  // Scoreboard
  logic [31:0] exp_q[$];
  int          got_rd = 0;
  logic [31:0] model_cmd = 32'h0;

  // Per-transaction deltas
  int d_valid, d_req, d_miss, d_ferr, d_miso;

  // Snapshot taken while reset is applied mid-frame
  logic        s_miso, s_valid, s_req, s_miss, s_ferr, s_busy;
  logic [31:0] s_cmd;
  int          s_n_ferr, s_n_valid, s_n_busy, s_n_miso;

  always #5 clk = ~clk;

  spi_slave_responder #(.SYNC_STAGES(2), .READ_OPCODE(RD_OP)) dut (
    .CLOCK     (clk),
    .RESET     (RESET),
    .SPI_SCLK  (SPI_SCLK),
    .SPI_CS    (SPI_CS),
    .SPI_MOSI  (SPI_MOSI),
    .SPI_MISO  (SPI_MISO),
    .CMD_WORD  (CMD_WORD),
    .CMD_VALID (CMD_VALID),
    .RD_REQ    (RD_REQ),
    .RD_ACK    (RD_ACK),
    .RD_DATA   (RD_DATA),
    .RD_MISS   (RD_MISS),
    .FRAME_ERR (FRAME_ERR),
    .BUSY      (BUSY),
    .DBG_STATE (DBG_STATE)
  );

  always @(negedge clk) begin
    if (CMD_VALID) begin
      n_valid++;
      got_q.push_back(CMD_WORD);
    end
    if (RD_REQ)    n_req++;
    if (RD_MISS)   n_miss++;
    if (FRAME_ERR) n_ferr++;
    if (SPI_MISO)  n_miso_hi++;
    if (BUSY)      n_busy++;
    if ((CMD_VALID && p_valid) || (RD_REQ && p_req) ||
        (RD_MISS && p_miss) || (FRAME_ERR && p_ferr)) n_consec++;
    p_valid = CMD_VALID;
    p_req   = RD_REQ;
    p_miss  = RD_MISS;
    p_ferr  = FRAME_ERR;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded 2ms without finishing");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------

  // One chip-select frame of nbits SCLK pulses. Returns the MISO bits sampled
  // at each rising edge. If rst_at >= 0, RESET is pulsed before that bit.
  task automatic spi_frame(input logic [31:0] word, input int nbits,
                           input int rst_at, output logic [31:0] rx);
    rx = '0;
    @(negedge clk);
    SPI_CS = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        RESET = 1'b1;
        repeat (2) @(negedge clk);
        s_miso = SPI_MISO;  s_valid = CMD_VALID; s_req = RD_REQ;
        s_miss = RD_MISS;   s_ferr  = FRAME_ERR; s_busy = BUSY;
        s_cmd  = CMD_WORD;
        s_n_ferr = n_ferr;  s_n_valid = n_valid;
        s_n_busy = n_busy;  s_n_miso  = n_miso_hi;
        RESET = 1'b0;
      end
      if (i < 32) SPI_MOSI = word[i];
      else        SPI_MOSI = 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk);
      SPI_SCLK = 1'b1;
      if (i < 32) rx[i] = SPI_MISO;
      repeat (HALF) @(negedge clk);
      SPI_SCLK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    SPI_CS   = 1'b1;
    SPI_MOSI = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  // Register-file side: waits for RD_REQ, acks after delay cycles, then
  // sends a second ack with different data that must be ignored.
  task automatic ack_driver(input int delay, input logic [31:0] data);
    bit seen = 0;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      if (RD_REQ) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL ack_wait: RD_REQ not seen within 1000 cycles");
    end else begin
      repeat (delay) @(negedge clk);
      RD_ACK = 1'b1; RD_DATA = data;
      @(negedge clk);
      RD_ACK = 1'b0;
      @(negedge clk);
      RD_ACK = 1'b1; RD_DATA = ~data;
      @(negedge clk);
      RD_ACK = 1'b0; RD_DATA = '0;
    end
  endtask

  // Command frame plus, when the command is a complete read, the read frame.
  // ack_mode: 0 = no ack, otherwise ack after ack_delay cycles.
  task automatic run_txn(input logic [31:0] word, input int nbits,
                         input int ack_mode, input int ack_delay,
                         input logic [31:0] data, input int rst_at,
                         output logic [31:0] rx);
    logic [31:0] cmd_rx;
    logic [31:0] rd_rx;
    int b_valid, b_req, b_miss, b_ferr, b_miso;
    bit is_read;
    is_read = (nbits == 32) && (word[3:0] == RD_OP);
    b_valid = n_valid; b_req = n_req; b_miss = n_miss;
    b_ferr  = n_ferr;  b_miso = n_miso_hi;
    rd_rx = '0;
    fork
      begin
        spi_frame(word, nbits, -1, cmd_rx);
        if (is_read) spi_frame(32'h0, 32, rst_at, rd_rx);
      end
      begin
        if (is_read && ack_mode != 0) ack_driver(ack_delay, data);
      end
    join
    rx = rd_rx;
    d_valid = n_valid - b_valid; d_req  = n_req - b_req;
    d_miss  = n_miss - b_miss;   d_ferr = n_ferr - b_ferr;
    d_miso  = n_miso_hi - b_miso;
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    RESET = 1'b1; SPI_SCLK = 1'b0; SPI_CS = 1'b1; SPI_MOSI = 1'b0;
    RD_ACK = 1'b0; RD_DATA = '0;
    repeat (6) @(negedge clk);
    n_checks++; if (SPI_MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", SPI_MISO); end
    n_checks++; if (CMD_WORD !== 32'h0) begin n_fail++; $display("FAIL reset_cmd_word: got %h expected 00000000", CMD_WORD); end
    n_checks++; if (CMD_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b expected 0", CMD_VALID); end
    n_checks++; if (RD_REQ !== 1'b0) begin n_fail++; $display("FAIL reset_rd_req: got %b expected 0", RD_REQ); end
    n_checks++; if (RD_MISS !== 1'b0) begin n_fail++; $display("FAIL reset_rd_miss: got %b expected 0", RD_MISS); end
    n_checks++; if (FRAME_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", FRAME_ERR); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    RESET = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", BUSY); end
  endtask

  task automatic test_write();
    logic [31:0] rx;
    run_txn(32'h12345670, 32, 0, 0, 32'h0, -1, rx);
    model_cmd = 32'h12345670;
    n_checks++; if (d_valid != 1) begin n_fail++; $display("FAIL write_valid_count: got %0d expected 1", d_valid); end
    n_checks++; if (CMD_WORD !== model_cmd) begin n_fail++; $display("FAIL write_cmd_word: got %h expected %h", CMD_WORD, model_cmd); end
    n_checks++; if (d_req != 0) begin n_fail++; $display("FAIL write_rd_req: got %0d expected 0", d_req); end
    n_checks++; if (d_miso != 0) begin n_fail++; $display("FAIL write_miso_high_cycles: got %0d expected 0", d_miso); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL write_busy_after: got %b expected 0", BUSY); end
    n_checks++; if (d_ferr != 0) begin n_fail++; $display("FAIL write_frame_err: got %0d expected 0", d_ferr); end
  endtask

  task automatic test_read_same_cycle();
    logic [31:0] rx;
    run_txn(32'hA5A5000E, 32, 1, 0, 32'hDEADBEEF, -1, rx);
    model_cmd = 32'hA5A5000E;
    n_checks++; if (rx !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_ack0_data: got %h expected deadbeef", rx); end
    n_checks++; if (d_req != 1) begin n_fail++; $display("FAIL read_ack0_req: got %0d expected 1", d_req); end
    n_checks++; if (d_miss != 0) begin n_fail++; $display("FAIL read_ack0_miss: got %0d expected 0", d_miss); end
    n_checks++; if (d_ferr != 0) begin n_fail++; $display("FAIL read_ack0_ferr: got %0d expected 0", d_ferr); end
    n_checks++; if (CMD_WORD !== model_cmd) begin n_fail++; $display("FAIL read_ack0_cmd: got %h expected %h", CMD_WORD, model_cmd); end
  endtask

  task automatic test_read_miss();
    logic [31:0] rx;
    run_txn(32'h0000000E, 32, 0, 0, 32'h0, -1, rx);
    model_cmd = 32'h0000000E;
    n_checks++; if (d_miss != 1) begin n_fail++; $display("FAIL read_miss_pulse: got %0d expected 1", d_miss); end
    n_checks++; if (rx !== 32'h0) begin n_fail++; $display("FAIL read_miss_data: got %h expected 00000000", rx); end
    n_checks++; if (d_ferr != 0) begin n_fail++; $display("FAIL read_miss_ferr: got %0d expected 0", d_ferr); end
  endtask

  task automatic test_short_frame();
    logic [31:0] rx;
    run_txn(32'hFFFF3A5B, 17, 0, 0, 32'h0, -1, rx);
    n_checks++; if (d_ferr != 1) begin n_fail++; $display("FAIL short_ferr: got %0d expected 1", d_ferr); end
    n_checks++; if (d_valid != 0) begin n_fail++; $display("FAIL short_valid: got %0d expected 0", d_valid); end
    n_checks++; if (CMD_WORD !== model_cmd) begin n_fail++; $display("FAIL short_cmd_hold: got %h expected %h", CMD_WORD, model_cmd); end
    run_txn(32'h00000001, 32, 0, 0, 32'h0, -1, rx);
    model_cmd = 32'h00000001;
    n_checks++; if (d_valid != 1) begin n_fail++; $display("FAIL short_next_valid: got %0d expected 1", d_valid); end
    n_checks++; if (CMD_WORD !== model_cmd) begin n_fail++; $display("FAIL short_next_cmd: got %h expected %h", CMD_WORD, model_cmd); end
  endtask

  task automatic test_overrun();
    logic [31:0] rx;
    run_txn($urandom, 33, 0, 0, 32'h0, -1, rx);
    n_checks++; if (d_ferr != 1) begin n_fail++; $display("FAIL overrun_ferr: got %0d expected 1", d_ferr); end
    n_checks++; if (d_valid != 0) begin n_fail++; $display("FAIL overrun_valid: got %0d expected 0", d_valid); end
    n_checks++; if (CMD_WORD !== model_cmd) begin n_fail++; $display("FAIL overrun_cmd_hold: got %h expected %h", CMD_WORD, model_cmd); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] rx;
    run_txn(32'h0000000E, 32, 1, 2, 32'hDEADBEEF, 10, rx);
    model_cmd = 32'h0;
    n_checks++; if (s_miso !== 1'b0) begin n_fail++; $display("FAIL rst_mid_miso: got %b expected 0", s_miso); end
    n_checks++; if (s_cmd !== 32'h0) begin n_fail++; $display("FAIL rst_mid_cmd: got %h expected 00000000", s_cmd); end
    n_checks++; if ({s_valid, s_req, s_miss, s_ferr, s_busy} !== 5'b0) begin n_fail++; $display("FAIL rst_mid_flags: got %b expected 00000", {s_valid, s_req, s_miss, s_ferr, s_busy}); end
    n_checks++; if (n_ferr - s_n_ferr != 0) begin n_fail++; $display("FAIL rst_mid_ferr: got %0d expected 0", n_ferr - s_n_ferr); end
    n_checks++; if (n_busy - s_n_busy != 0) begin n_fail++; $display("FAIL rst_mid_busy_cycles: got %0d expected 0", n_busy - s_n_busy); end
    n_checks++; if (n_miso_hi - s_n_miso != 0) begin n_fail++; $display("FAIL rst_mid_miso_cycles: got %0d expected 0", n_miso_hi - s_n_miso); end
    n_checks++; if (n_valid - s_n_valid != 0) begin n_fail++; $display("FAIL rst_mid_valid: got %0d expected 0", n_valid - s_n_valid); end
    run_txn(32'h0000ABC0, 32, 0, 0, 32'h0, -1, rx);
    model_cmd = 32'h0000ABC0;
    n_checks++; if (d_valid != 1) begin n_fail++; $display("FAIL rst_next_valid: got %0d expected 1", d_valid); end
    n_checks++; if (CMD_WORD !== model_cmd) begin n_fail++; $display("FAIL rst_next_cmd: got %h expected %h", CMD_WORD, model_cmd); end
  endtask

  // Random frames checked against the outcome model: a frame is a command
  // only with exactly 32 edges; it is a read when its low nibble is the read
  // opcode; the master then receives the acked data, or zero with a miss.
  task automatic test_random();
    logic [31:0] word, data, rx, exp_rx, got;
    int nbits, ack_mode, ack_delay, r;
    bit exp_valid, exp_read;
    got_rd = got_q.size();
    for (int it = 0; it < 10; it++) begin
      word = $urandom;
      if ($urandom_range(0, 1) == 1) word[3:0] = RD_OP;
      r = $urandom_range(0, 9);
      if (r == 7)      nbits = $urandom_range(1, 31);
      else if (r == 8) nbits = $urandom_range(33, 36);
      else             nbits = 32;
      ack_mode  = $urandom_range(0, 2);
      ack_delay = (ack_mode == 2) ? $urandom_range(1, 8) : 0;
      data      = $urandom;
      exp_valid = (nbits == 32);
      exp_read  = exp_valid && (word[3:0] == RD_OP);
      exp_rx    = (ack_mode != 0) ? data : 32'h0;
      if (exp_valid) begin
        exp_q.push_back(word);
        model_cmd = word;
      end
      run_txn(word, nbits, ack_mode, ack_delay, data, -1, rx);
      n_checks++; if (d_valid != int'(exp_valid)) begin n_fail++; $display("FAIL rand%0d_valid: got %0d expected %0d", it, d_valid, exp_valid); end
      n_checks++; if (d_ferr != int'(!exp_valid)) begin n_fail++; $display("FAIL rand%0d_ferr: got %0d expected %0d", it, d_ferr, !exp_valid); end
      n_checks++; if (d_req != int'(exp_read)) begin n_fail++; $display("FAIL rand%0d_req: got %0d expected %0d", it, d_req, exp_read); end
      n_checks++; if (CMD_WORD !== model_cmd) begin n_fail++; $display("FAIL rand%0d_cmd: got %h expected %h", it, CMD_WORD, model_cmd); end
      if (exp_read) begin
        n_checks++; if (rx !== exp_rx) begin n_fail++; $display("FAIL rand%0d_rdata: got %h expected %h", it, rx, exp_rx); end
        n_checks++; if (d_miss != int'(ack_mode == 0)) begin n_fail++; $display("FAIL rand%0d_miss: got %0d expected %0d", it, d_miss, ack_mode == 0); end
      end else begin
        n_checks++; if (d_miso != 0) begin n_fail++; $display("FAIL rand%0d_miso_idle: got %0d expected 0", it, d_miso); end
      end
      while (got_rd < got_q.size()) begin
        got = got_q[got_rd];
        got_rd++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_scoreboard: unexpected CMD_WORD %h", got);
        end else if (got !== exp_q[0]) begin
          n_fail++; $display("FAIL rand_scoreboard: got %h expected %h", got, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_scoreboard_left: got %0d pending expected 0", exp_q.size()); end
  endtask

  task automatic test_pulse_spacing();
    n_checks++; if (n_consec != 0) begin n_fail++; $display("FAIL pulse_spacing: got %0d back-to-back pulses expected 0", n_consec); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL final_busy: got %b expected 0", BUSY); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_same_cycle();
    test_read_miss();
    test_short_frame();
    test_overrun();
    test_reset_mid_read();
    test_random();
    test_pulse_spacing();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_responder.md
# spi_slave_responder

SPI target-side responder for the board's 32-bit command link: receives 32-bit command words LSB-first from the controller's SPI master. For read commands (`CMD_WORD[3:0] == READ_OPCODE`), it returns a 32-bit data word LSB-first in the follow-on chip-select frame. All SPI inputs are oversampled in the `CLOCK` domain, and SPI_SCLK is never used as a clock. The block sits between the SPI pins and the register file, which supplies read data through a request/acknowledge handshake.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops on `SPI_SCLK`, `SPI_CS` and `SPI_MOSI`.
- `READ_OPCODE`, default 4'b1110: value of `CMD_WORD[3:0]` that triggers a read-back frame.
- `CLOCK` in 1: system clock; must be at least 8× the `SPI_SCLK` frequency.
- `RESET` in 1: synchronous, active-high reset.
- `SPI_SCLK` in 1: SPI clock, idle low; MOSI is valid on the rising edge.
- `SPI_CS` in 1: chip select, active low.
- `SPI_MOSI` in 1: serial data from the master.
- `SPI_MISO` out 1: serial data to the master; the master samples it on the `SPI_SCLK` rising edge.
- `CMD_WORD` out 32: last complete command word; bit 0 is the first bit received.
- `CMD_VALID` out 1: one-cycle pulse when `CMD_WORD` updates.
- `RD_REQ` out 1: one-cycle pulse, same cycle as `CMD_VALID`, for read commands only.
- `RD_ACK` in 1: register file presents `RD_DATA`; sampled only while a read is pending.
- `RD_DATA` in 32: read-back word, captured on the `RD_ACK` cycle.
- `RD_MISS` out 1: one-cycle pulse when the read frame starts with no `RD_ACK` received.
- `FRAME_ERR` out 1: one-cycle pulse on a malformed frame.
- `BUSY` out 1: high in any state other than IDLE.

## Operation
- **Edge detection.** Edges are detected on the synchronized signals using a registered previous value.
  - A SCLK rise is `prev == 0 && now == 1`.
  - CS fall and CS rise are detected the same way.
- **IDLE.** The bit counter clears on entry.
  - On CS fall: go to CMD_SHIFT.
- **CMD_SHIFT.** On each SCLK rise with CS low:
  - Shift MOSI into bit `[count]` of the command shift register; increment the 6-bit counter.
  - Edges after the 32nd set an overrun flag and are otherwise ignored.
- **CMD_SHIFT, on CS rise:**
  - If count == 32 and no overrun: load `CMD_WORD` and pulse `CMD_VALID`.
  - If additionally `[3:0] == READ_OPCODE`: pulse `RD_REQ` and go to RD_WAIT.
  - Otherwise go to IDLE.
  - Any other count, or overrun: pulse `FRAME_ERR`, leave `CMD_WORD` unchanged, go to IDLE.
- **RD_WAIT.** Waits for CS low.
  - `RD_ACK` high: load the TX shift register from `RD_DATA` and set `ack_seen`.
  - Only the first `RD_ACK` is used; later ones are ignored.
  - `RD_ACK` in the same cycle as `RD_REQ` is legal and must be captured.
  - On CS fall: if `ack_seen` is clear, load TX with 0 and pulse `RD_MISS`. Then go to RD_SHIFT.
- **RD_SHIFT.**
  - `SPI_MISO` = TX bit 0 from the CS-fall cycle onward.
  - On each SCLK rise: increment the counter.
  - On each SCLK fall: shift TX right by one, filling with 0.
  - On CS rise: count == 32 goes to IDLE; any other count pulses `FRAME_ERR` and goes to IDLE.
- **SPI_MISO outside RD_SHIFT.** Driven 0 (single target, no tristate).
- **Reset values.**
  - State IDLE.
  - `SPI_MISO`, `CMD_VALID`, `RD_REQ`, `RD_MISS`, `FRAME_ERR`, `BUSY` = 0.
  - `CMD_WORD` = 0.
  - Shift registers, counter and `ack_seen` = 0.
- **Reset mid-frame.** Everything returns to reset values.
  - If synchronized CS is low when `RESET` deasserts, stay in IDLE until a CS rise is seen.
  - No `FRAME_ERR` is reported for that partial frame.

## Timing
- Input path latency: SYNC_STAGES + 1 `CLOCK` cycles from a pin edge to edge detection.
- `CMD_VALID` / `RD_REQ`: asserted the cycle after a CS rise is detected, i.e. SYNC_STAGES + 2 cycles after the CS pin rises.
- `SPI_MISO` update: registered, SYNC_STAGES + 2 cycles after the SCLK pin falls.
  - Must settle before the next SCLK rise, hence the ≥8× clock ratio.
  - First read bit is valid SYNC_STAGES + 2 cycles after the CS pin falls.
- Read-data deadline: `RD_ACK` must arrive before the detected read-frame CS fall.
  - With a one-SCLK-period CS gap from the master, this gives ≥2 `CLOCK` cycles after `RD_REQ`.
- Simultaneous events in one cycle:
  - CS rise wins over a SCLK edge; that SCLK edge is discarded.
  - CS fall while in IDLE with a SCLK rise: the SCLK rise is ignored.
- All single-cycle pulses are never asserted on consecutive cycles.

## Test plan
- **Write command.** Send 0x12345670. Expect:
  - exactly one `CMD_VALID` pulse, with `CMD_WORD` = 0x12345670;
  - no `RD_REQ`;
  - `SPI_MISO` = 0 throughout;
  - `BUSY` low after the CS rise.
- **Read with same-cycle ack.** Send 0xA5A5000E and drive `RD_ACK` with `RD_DATA` = 0xDEADBEEF in the `RD_REQ` cycle. Expect:
  - the model master captures 0xDEADBEEF over 32 bits;
  - no `RD_MISS`; no `FRAME_ERR`.
- **Read, never acked.** Send 0x0000000E with no `RD_ACK`. Expect:
  - one `RD_MISS` pulse at the read CS fall;
  - master captures 0x00000000.
- **Short frame.** CS rises after 17 SCLK edges. Expect:
  - one `FRAME_ERR` pulse; no `CMD_VALID`; `CMD_WORD` holds its prior value;
  - the next full frame 0x00000001 decodes correctly.
- **Overrun.** 33 SCLK edges in one command frame. Expect:
  - one `FRAME_ERR` pulse; no `CMD_VALID`.
- **Reset mid-read.** Assert `RESET` at read bit 10. Expect:
  - all outputs at reset values;
  - the remainder of the frame ignored, with no `FRAME_ERR`;
  - the following frame 0x0000ABC0 yields `CMD_VALID` with the correct word.
